// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, frame period and decoder state type for pwm_decoder
package pwm_pkg;

  localparam int PWM_WIDTH  = 8;
  localparam int PWM_PERIOD = 256;
  localparam int CNT_WIDTH  = $clog2(PWM_PERIOD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } pwm_state_t;

  // A full frame can hold PWM_PERIOD high cycles, one more than the sample can express.
  function automatic logic [PWM_WIDTH-1:0] sat_duty(input logic [CNT_WIDTH:0] n);
    logic [CNT_WIDTH:0] max_val;
    max_val = (CNT_WIDTH+1)'((1 << PWM_WIDTH) - 1);
    if (n > max_val) begin
      return PWM_WIDTH'(max_val);
    end
    return n[PWM_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - optional 2-flop input synchronizer (PWM_DECODER_SYNC_EN) and rising-edge detector
module pwm_edge_sync (
  input  logic clk,
  input  logic nrst,
  input  logic pwm_i,
  output logic pwm_s,
  output logic rise
);

`ifdef PWM_DECODER_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pwm_i};
    end
  end

  assign pwm_s = sync_q[1];
`else
  assign pwm_s = pwm_i;
`endif

  logic prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= pwm_s;
    end
  end

  assign rise = pwm_s & ~prev_q;

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - PWM duty decoder, 256-cycle high-first frames; PWM_DECODER_SYNC_EN adds an input synchronizer
module pwm_decoder
  import pwm_pkg::*;
(
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 en,
  input  logic                 pwm_i,
  output logic [PWM_WIDTH-1:0] sample_o,
  output logic                 valid_o,
  output logic                 locked_o,
  output logic                 resync_err_o
);

  localparam logic [CNT_WIDTH-1:0] LAST_CYCLE = CNT_WIDTH'(PWM_PERIOD - 1);

  pwm_state_t           state;
  logic [CNT_WIDTH-1:0] timeout_cnt;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic [CNT_WIDTH:0]   high_cnt;
  logic [CNT_WIDTH:0]   high_next;
  logic                 pwm_s;
  logic                 rise;

  pwm_edge_sync u_edge_sync (
    .clk   (clk),
    .nrst  (nrst),
    .pwm_i (pwm_i),
    .pwm_s (pwm_s),
    .rise  (rise)
  );

  assign high_next = high_cnt + {{CNT_WIDTH{1'b0}}, pwm_s};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      timeout_cnt  <= '0;
      frame_cnt    <= '0;
      high_cnt     <= '0;
      sample_o     <= '0;
      valid_o      <= 1'b0;
      locked_o     <= 1'b0;
      resync_err_o <= 1'b0;
    end else begin
      valid_o      <= 1'b0;
      resync_err_o <= 1'b0;
      if (!en) begin
        // Dropping enable throws away any partial frame.
        state       <= ST_IDLE;
        locked_o    <= 1'b0;
        timeout_cnt <= '0;
        frame_cnt   <= '0;
        high_cnt    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state       <= ST_ACQUIRE;
            timeout_cnt <= '0;
          end
          ST_ACQUIRE: begin
            if (rise) begin
              // The edge cycle itself is frame cycle 0 and already counts as high.
              state     <= ST_LOCKED;
              locked_o  <= 1'b1;
              frame_cnt <= CNT_WIDTH'(1);
              high_cnt  <= (CNT_WIDTH+1)'(1);
            end else if (timeout_cnt == LAST_CYCLE) begin
              state     <= ST_LOCKED;
              locked_o  <= 1'b1;
              frame_cnt <= '0;
              high_cnt  <= '0;
            end else begin
              timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
            end
          end
          ST_LOCKED: begin
            if (rise && (frame_cnt != '0)) begin
              resync_err_o <= 1'b1;
              frame_cnt    <= CNT_WIDTH'(1);
              high_cnt     <= (CNT_WIDTH+1)'(1);
            end else if (frame_cnt == LAST_CYCLE) begin
              sample_o  <= sat_duty(high_next);
              valid_o   <= 1'b1;
              frame_cnt <= '0;
              high_cnt  <= '0;
            end else begin
              frame_cnt <= frame_cnt + CNT_WIDTH'(1);
              high_cnt  <= high_next;
            end
          end
          default: begin
            state    <= ST_IDLE;
            locked_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - self-checking bench for pwm_decoder against a frame-window reference model
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       en = 1'b0;
  logic       pwm_i = 1'b0;
  logic [7:0] sample_o;
  logic       valid_o;
  logic       locked_o;
  logic       resync_err_o;

`ifdef PWM_DECODER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif
  localparam int HN = 65536;

  pwm_decoder dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .pwm_i        (pwm_i),
    .sample_o     (sample_o),
    .valid_o      (valid_o),
    .locked_o     (locked_o),
    .resync_err_o (resync_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: cycle index since reset, frame start positions, and a history of the decoded line.
  int         t;
  int         mode;
  int         acq_start;
  int         frame_start;
  logic [7:0] m_sample;
  bit         m_valid;
  bit         m_err;
  bit         pi_h[HN];
  bit         ps_h[HN];

  int duty;
  int k;
  int valid_seen;
  int err_seen;

  typedef struct packed {
    int         duty;
    int         frames;
    logic [7:0] exp_sample;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  task automatic model_step(input bit e, input bit p);
    bit ps;
    bit prev;
    bit rise;
    int pos;
    int sum;
    pi_h[t % HN] = p;
    ps = (t >= D) ? pi_h[(t - D) % HN] : 1'b0;
    ps_h[t % HN] = ps;
    prev = (t > 0) ? ps_h[(t - 1) % HN] : 1'b0;
    rise = ps && !prev;
    m_valid = 1'b0;
    m_err = 1'b0;
    if (!e) begin
      mode = 0;
    end else if (mode == 0) begin
      mode = 1;
      acq_start = t + 1;
    end else if (mode == 1) begin
      if (rise) begin
        mode = 2;
        frame_start = t;
      end else if (t - acq_start >= 255) begin
        mode = 2;
        frame_start = t + 1;
      end
    end else begin
      pos = t - frame_start;
      if (rise && pos != 0) begin
        m_err = 1'b1;
        frame_start = t;
      end else if (pos == 255) begin
        sum = 0;
        for (int i = 0; i < 256; i++) sum += int'(ps_h[(t - i) % HN]);
        m_sample = (sum > 255) ? 8'd255 : 8'(sum);
        m_valid = 1'b1;
        frame_start = t + 1;
      end
    end
    t++;
  endtask

  task automatic tick(input bit e, input bit p);
    en = e;
    pwm_i = p;
    @(posedge clk);
    model_step(e, p);
    #1;
    check("cycle {locked,valid,err,sample}",
          {21'd0, locked_o, valid_o, resync_err_o, sample_o},
          {21'd0, (mode == 2), m_valid, m_err, m_sample});
    valid_seen += int'(valid_o);
    err_seen += int'(resync_err_o);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      tick(e, (k % 256) < duty);
      k++;
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    #1;
    check("reset_async_out", {valid_o, locked_o, resync_err_o, sample_o}, 11'd0);
    for (int i = 0; i < 3; i++) begin
      en = 1'($urandom);
      pwm_i = ~pwm_i;
      @(posedge clk);
      #1;
      check("reset_held_out", {valid_o, locked_o, resync_err_o, sample_o}, 11'd0);
    end
    t = 0;
    mode = 0;
    m_sample = 8'd0;
    m_valid = 1'b0;
    m_err = 1'b0;
    k = 0;
    nrst = 1'b1;
  endtask

  initial begin
    vec_t vecs[7];
    vecs = '{'{127, 3, 8'd127}, '{0, 2, 8'd0}, '{256, 3, 8'd255}, '{255, 3, 8'd255},
             '{1, 3, 8'd1}, '{254, 3, 8'd254}, '{64, 2, 8'd64}};
    #2;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      duty = vecs[v].duty;
      valid_seen = 0;
      run((vecs[v].frames + 2) * 256 + 8, 1'b1);
      check("tbl_sample", sample_o, vecs[v].exp_sample);
      check("tbl_locked", locked_o, 1);
      check("tbl_valid_enough", valid_seen >= vecs[v].frames, 1);
    end

    // Extra edge at frame cycle 100 starts a new duty-64 frame.
    do_reset();
    duty = 64;
    run(4 * 256 + 20, 1'b1);
    while (k % 256 != 100) run(1, 1'b1);
    k = 0;
    err_seen = 0;
    valid_seen = 0;
    run(300, 1'b1);
    check("mis_err_count", err_seen, 1);
    check("mis_valid_count", valid_seen, 1);
    check("mis_sample", sample_o, 64);

    // Enable drop at frame cycle ~50, then re-acquire at a new duty.
    do_reset();
    duty = 127;
    run(4 * 256, 1'b1);
    check("drop_pre_sample", sample_o, 127);
    while (k % 256 != 50) run(1, 1'b1);
    valid_seen = 0;
    run(1, 1'b0);
    check("drop_locked_low", locked_o, 0);
    run(99, 1'b0);
    check("drop_no_valid", valid_seen, 0);
    check("drop_sample_hold", sample_o, 127);
    duty = 200;
    run(3 * 256 + 10, 1'b1);
    check("drop_relocked", locked_o, 1);
    check("drop_new_sample", sample_o, 200);

    // Randomized segments: duty changes, phase jumps, enable drops and mid-frame resets.
    do_reset();
    for (int s = 0; s < 14; s++) begin
      duty = $urandom_range(0, 256);
      case ($urandom_range(0, 3))
        0: run($urandom_range(300, 900), 1'b1);
        1: begin
          run($urandom_range(100, 600), 1'b1);
          k = 0;
          run($urandom_range(100, 600), 1'b1);
        end
        2: begin
          run($urandom_range(100, 600), 1'b1);
          run($urandom_range(1, 300), 1'b0);
          run($urandom_range(300, 900), 1'b1);
        end
        default: begin
          run($urandom_range(100, 600), 1'b1);
          do_reset();
          check("rand_reset_sample", sample_o, 0);
          run($urandom_range(300, 900), 1'b1);
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
